// File: rtl/muldiv_unit.sv
// E-stage multiply/divide unit with the architectural HI/LO registers.
// Results are computed at start and held in pending registers; a countdown
// models the multi-cycle latency, and HI/LO are committed when it expires.
module muldiv_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  MulDivOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Req,
    output logic        MulDiv_busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MulDiv_RD
);

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MFHI  = 4'd7,
        OP_MFLO  = 4'd8
    } op_e;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    op_e              op;
    logic [CNT_W-1:0] count;
    logic             idle;
    logic             accept;
    logic             start;
    logic             is_mul;

    logic [31:0]      pend_hi;
    logic [31:0]      pend_lo;
    logic             pend_wr;

    logic [31:0]      res_hi;
    logic [31:0]      res_lo;
    logic             res_wr;

    logic [63:0]      prod;
    logic [31:0]      a_mag;
    logic [31:0]      b_mag;
    logic [31:0]      divisor;
    logic [31:0]      q_mag;
    logic [31:0]      r_mag;

    // Decode the E-stage op; unused encodings behave as no-op
    always_comb begin
        op = OP_NONE;
        if (MulDivOp <= 4'd8) begin
            op = op_e'(MulDivOp);
        end
    end

    assign idle        = (count == '0);
    assign accept      = idle && !Req;
    assign is_mul      = (op == OP_MULT) || (op == OP_MULTU);
    assign start       = accept && (is_mul || (op == OP_DIV) || (op == OP_DIVU));
    assign MulDiv_busy = start || !idle;

    // Compute the result of the op currently in E from A/B
    always_comb begin
        prod    = '0;
        a_mag   = A;
        b_mag   = B;
        divisor = 32'd1;
        q_mag   = '0;
        r_mag   = '0;
        res_hi  = '0;
        res_lo  = '0;
        res_wr  = 1'b1;
        case (op)
            OP_MULT: begin
                prod   = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
                res_hi = prod[63:32];
                res_lo = prod[31:0];
            end
            OP_MULTU: begin
                prod   = {32'd0, A} * {32'd0, B};
                res_hi = prod[63:32];
                res_lo = prod[31:0];
            end
            OP_DIV: begin
                // Signed divide via magnitudes: truncation toward zero and the
                // 0x80000000 / -1 case both fall out without signed overflow.
                a_mag   = A[31] ? (~A + 32'd1) : A;
                b_mag   = B[31] ? (~B + 32'd1) : B;
                divisor = (B == '0) ? 32'd1 : b_mag;
                q_mag   = a_mag / divisor;
                r_mag   = a_mag % divisor;
                res_lo  = (A[31] ^ B[31]) ? (~q_mag + 32'd1) : q_mag;
                res_hi  = A[31] ? (~r_mag + 32'd1) : r_mag;
                res_wr  = (B != '0);
            end
            OP_DIVU: begin
                divisor = (B == '0) ? 32'd1 : B;
                res_lo  = A / divisor;
                res_hi  = A % divisor;
                res_wr  = (B != '0);
            end
            default: res_wr = 1'b0;
        endcase
    end

    // Countdown, pending-result latch, HI/LO commit and mthi/mtlo writes
    always_ff @(posedge clk) begin
        if (reset) begin
            count   <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_wr <= 1'b0;
            HI      <= '0;
            LO      <= '0;
        end else begin
            if (start) begin
                count   <= is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                pend_hi <= res_hi;
                pend_lo <= res_lo;
                pend_wr <= res_wr;
            end else if (!idle) begin
                count <= count - CNT_W'(1);
                if ((count == CNT_W'(1)) && pend_wr) begin
                    HI <= pend_hi;
                    LO <= pend_lo;
                end
            end
            if (accept && (op == OP_MTHI)) begin
                HI <= A;
            end
            if (accept && (op == OP_MTLO)) begin
                LO <= A;
            end
        end
    end

    // Read port for mfhi/mflo straight from the architectural registers
    always_comb begin
        MulDiv_RD = '0;
        if (op == OP_MFHI) begin
            MulDiv_RD = HI;
        end else if (op == OP_MFLO) begin
            MulDiv_RD = LO;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: expected HI/LO and busy length are
// queued when an op is issued and compared when the unit goes idle.
module tb_muldiv_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk;
    logic        reset;
    logic [3:0]  MulDivOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Req;
    logic        MulDiv_busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MulDiv_RD;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int unsigned cycles;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic [31:0] m_hi     = '0;
    logic [31:0] m_lo     = '0;

    muldiv_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk        (clk),
        .reset      (reset),
        .MulDivOp   (MulDivOp),
        .A          (A),
        .B          (B),
        .Req        (Req),
        .MulDiv_busy(MulDiv_busy),
        .HI         (HI),
        .LO         (LO),
        .MulDiv_RD  (MulDiv_RD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic req);
        MulDivOp = op;
        A        = a;
        B        = b;
        Req      = req;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a start op, measure busy length, then score HI/LO against the queue
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input int unsigned n);
        exp_t        e;
        int unsigned cnt;
        int unsigned guard;
        sb.push_back('{hi: exp_hi, lo: exp_lo, cycles: n + 1});
        drive(op, a, b, 1'b0);
        #1;
        cnt = MulDiv_busy ? 1 : 0;
        tick();
        drive(4'd0, '0, '0, 1'b0);
        guard = 0;
        while (MulDiv_busy && guard < 100) begin
            cnt++;
            guard++;
            tick();
        end
        e = sb.pop_front();
        check({tag, "_busy"}, 64'(cnt), 64'(e.cycles));
        check({tag, "_hi"}, 64'(HI), 64'(e.hi));
        check({tag, "_lo"}, 64'(LO), 64'(e.lo));
        m_hi = e.hi;
        m_lo = e.lo;
    endtask

    task automatic read_hilo(input string tag, input logic [3:0] op, input logic [31:0] exp);
        drive(op, '0, '0, 1'b0);
        #1;
        check(tag, 64'(MulDiv_RD), 64'(exp));
        tick();
        drive(4'd0, '0, '0, 1'b0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        longint      sp;
        logic [63:0] up;

        reset = 1'b1;
        drive(4'd0, '0, '0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rst_busy", 64'(MulDiv_busy), 64'd0);
        check("rst_hi", 64'(HI), 64'd0);
        check("rst_lo", 64'(LO), 64'd0);
        check("rst_rd", 64'(MulDiv_RD), 64'd0);

        // Signed multiply, then mfhi in the following cycle
        run_op("mult_neg", 4'd1, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, MULT_N);
        read_hilo("mfhi_after_mult", 4'd7, 32'hFFFFFFFF);

        // Signed and unsigned divide of the same operands
        run_op("div_neg", 4'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, DIV_N);
        run_op("divu", 4'd4, 32'hFFFFFFF9, 32'd2, 32'd1, 32'h7FFFFFFC, DIV_N);
        run_op("div_ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, DIV_N);

        // mthi/mtlo back to back, never busy
        drive(4'd5, 32'h1234, '0, 1'b0);
        #1;
        check("mthi_busy", 64'(MulDiv_busy), 64'd0);
        tick();
        drive(4'd6, 32'h5678, '0, 1'b0);
        #1;
        check("mtlo_busy", 64'(MulDiv_busy), 64'd0);
        check("mthi_hi", 64'(HI), 64'h1234);
        tick();
        drive(4'd0, '0, '0, 1'b0);
        check("mtlo_lo", 64'(LO), 64'h5678);
        m_hi = 32'h1234;
        m_lo = 32'h5678;
        read_hilo("mflo", 4'd8, 32'h5678);
        #1;
        check("rd_none", 64'(MulDiv_RD), 64'd0);
        read_hilo("rd_op12", 4'd12, 32'd0);

        // Divide by zero leaves preset HI/LO untouched
        drive(4'd5, 32'h11, '0, 1'b0);
        tick();
        drive(4'd6, 32'h22, '0, 1'b0);
        tick();
        run_op("divu_zero", 4'd4, 32'd5, 32'd0, 32'h11, 32'h22, DIV_N);
        run_op("div_zero", 4'd3, 32'hFFFFFF00, 32'd0, 32'h11, 32'h22, DIV_N);

        // Randomised multiplies and unsigned divides against a longint model
        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom;
            up = {32'd0, ra} * {32'd0, rb};
            run_op("multu_rnd", 4'd2, ra, rb, up[63:32], up[31:0], MULT_N);
            sp = longint'($signed(ra)) * longint'($signed(rb));
            run_op("mult_rnd", 4'd1, ra, rb, sp[63:32], sp[31:0], MULT_N);
            rb = $urandom_range(1, 32'hFFFF);
            run_op("divu_rnd", 4'd4, ra, rb, ra % rb, ra / rb, DIV_N);
        end

        // Flushed start: nothing counts, HI/LO unchanged
        drive(4'd1, 32'd100, 32'd100, 1'b1);
        tick();
        drive(4'd0, '0, '0, 1'b0);
        check("req_mult_busy", 64'(MulDiv_busy), 64'd0);
        for (int i = 0; i < MULT_N + 1; i++) tick();
        check("req_mult_hi", 64'(HI), 64'(m_hi));
        check("req_mult_lo", 64'(LO), 64'(m_lo));
        drive(4'd5, 32'hDEAD, '0, 1'b1);
        tick();
        drive(4'd0, '0, '0, 1'b0);
        check("req_mthi_hi", 64'(HI), 64'(m_hi));

        // Reset in the third busy cycle aborts the multu
        drive(4'd2, 32'd7, 32'd9, 1'b0);
        tick();
        drive(4'd0, '0, '0, 1'b0);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_mid_busy", 64'(MulDiv_busy), 64'd0);
        check("rst_mid_hi", 64'(HI), 64'd0);
        check("rst_mid_lo", 64'(LO), 64'd0);
        for (int i = 0; i < MULT_N + 3; i++) tick();
        check("rst_late_hi", 64'(HI), 64'd0);
        check("rst_late_lo", 64'(LO), 64'd0);
        check("rst_late_busy", 64'(MulDiv_busy), 64'd0);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
